// File: rtl/uart_rx_core_if.sv
// Signal bundle between the UART receive engine and its environment
// (line, enable, divisor, FIFO flag in; byte, strobes, status out).
interface uart_rx_if;
  logic        rx_en_i;
  logic [15:0] clks_per_bit_i;
  logic        rx_i;
  logic        fifo_full_i;
  logic [7:0]  data_o;
  logic        wr_en_o;
  logic        frame_err_o;
  logic        overrun_o;
  logic        busy_o;

  modport master (
    output rx_en_i, clks_per_bit_i, rx_i, fifo_full_i,
    input  data_o, wr_en_o, frame_err_o, overrun_o, busy_o
  );

  modport slave (
    input  rx_en_i, clks_per_bit_i, rx_i, fifo_full_i,
    output data_o, wr_en_o, frame_err_o, overrun_o, busy_o
  );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receive engine: synchronises rx, deserialises LSB-first frames and
// emits one-cycle write / framing-error / overrun pulses toward the RX FIFO.
module uart_rx_core (
  input  logic      clk_i,
  input  logic      rst_i,
  uart_rx_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_reg;
  logic        s1_reg, s2_reg, prev_reg;
  logic [15:0] cnt_reg;
  logic [15:0] div_reg;
  logic [2:0]  idx_reg;
  logic [7:0]  shift_reg;
  logic [7:0]  data_reg;
  logic        wr_en_reg, frame_err_reg, overrun_reg, busy_reg;

  logic        fall_edge;
  logic [15:0] div_clamped;
  logic [15:0] half_tgt;
  logic [15:0] bit_tgt;

  assign fall_edge   = ~s2_reg & prev_reg;
  assign div_clamped = (bus.clks_per_bit_i < 16'd4) ? 16'd4 : bus.clks_per_bit_i;
  // START is entered one cycle after the edge is visible on s2, so the
  // half-bit target is shortened by one to land the sample mid start bit.
  assign half_tgt    = (div_reg >> 1) - 16'd2;
  assign bit_tgt     = div_reg - 16'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_reg        <= 1'b1;
      s2_reg        <= 1'b1;
      prev_reg      <= 1'b1;
      state_reg     <= IDLE;
      cnt_reg       <= 16'd0;
      div_reg       <= 16'd4;
      idx_reg       <= 3'd0;
      shift_reg     <= 8'd0;
      data_reg      <= 8'd0;
      wr_en_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      s1_reg        <= bus.rx_i;
      s2_reg        <= s1_reg;
      prev_reg      <= s2_reg;
      wr_en_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;

      if (!bus.rx_en_i) begin
        state_reg <= IDLE;
        cnt_reg   <= 16'd0;
        idx_reg   <= 3'd0;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (fall_edge) begin
              state_reg <= START;
              cnt_reg   <= 16'd0;
              div_reg   <= div_clamped;
              busy_reg  <= 1'b1;
            end
          end
          START: begin
            if (cnt_reg == half_tgt) begin
              cnt_reg <= 16'd0;
              if (!s2_reg) begin
                state_reg <= DATA;
                idx_reg   <= 3'd0;
              end else begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
              end
            end else begin
              cnt_reg <= cnt_reg + 16'd1;
            end
          end
          DATA: begin
            if (cnt_reg == bit_tgt) begin
              cnt_reg   <= 16'd0;
              shift_reg <= {s2_reg, shift_reg[7:1]};
              idx_reg   <= idx_reg + 3'd1;
              if (idx_reg == 3'd7)
                state_reg <= STOP;
            end else begin
              cnt_reg <= cnt_reg + 16'd1;
            end
          end
          STOP: begin
            if (cnt_reg == bit_tgt) begin
              cnt_reg   <= 16'd0;
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
              if (!s2_reg) begin
                frame_err_reg <= 1'b1;
              end else if (bus.fifo_full_i) begin
                overrun_reg <= 1'b1;
              end else begin
                data_reg  <= shift_reg;
                wr_en_reg <= 1'b1;
              end
            end else begin
              cnt_reg <= cnt_reg + 16'd1;
            end
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data_o      = data_reg;
  assign bus.wr_en_o     = wr_en_reg;
  assign bus.frame_err_o = frame_err_reg;
  assign bus.overrun_o   = overrun_reg;
  assign bus.busy_o      = busy_reg;

endmodule
